// File: rtl/cache_nway_pkg.sv
// Shared types and defaults for the n-way write-back cache.
package cache_types;

    typedef logic [127:0] cache_line;
    typedef logic [15:0]  lc3b_word;

    typedef enum logic [1:0] {
        ST_CHECK     = 2'd0,
        ST_WRITEBACK = 2'd1,
        ST_FILL      = 2'd2
    } cache_state_e;

    localparam int DEF_WAYS = 4;
    localparam int DEF_SETS = 16;

    // Byte-enable merge of a CPU write into an existing 16-bit word.
    function automatic logic [15:0] merge_word(input logic [15:0] old_w,
                                               input logic [15:0] new_w,
                                               input logic [1:0]  be);
        return {be[1] ? new_w[15:8] : old_w[15:8],
                be[0] ? new_w[7:0]  : old_w[7:0]};
    endfunction

endpackage

// File: rtl/cache_plru.sv
// Per-set tree pseudo-LRU state. Node n has children 2n+1 (left) and 2n+2
// (right); a node bit of 0 points the victim search to the left subtree.
module cache_plru
    import cache_types::*;
#(
    parameter int WAYS = DEF_WAYS,
    parameter int SETS = DEF_SETS
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [$clog2(SETS)-1:0]  index,
    input  logic                     update,
    input  logic [$clog2(WAYS)-1:0]  way_hit,
    output logic [$clog2(WAYS)-1:0]  victim
);
    localparam int WAY_W = $clog2(WAYS);

    logic [WAYS-2:0] r_bits [SETS];
    int              w_prefix;
    logic            w_dir;

    // Walk the tree of the addressed set following the node bits to the victim leaf.
    always_comb begin
        w_prefix = 0;
        w_dir    = 1'b0;
        for (int l = 0; l < WAY_W; l++) begin
            w_dir = 1'b0;
            for (int k = 0; k < (1 << l); k++) begin
                if (k == w_prefix) begin
                    w_dir = r_bits[index][(1 << l) - 1 + k];
                end else begin
                    w_dir = w_dir;
                end
            end
            w_prefix = 2 * w_prefix + (w_dir ? 1 : 0);
        end
        victim = WAY_W'(w_prefix);
    end

    // On an access, make every node on the accessed way's path point away from it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                r_bits[s] <= '0;
            end
        end else if (update) begin
            for (int l = 0; l < WAY_W; l++) begin
                for (int k = 0; k < (1 << l); k++) begin
                    if ((int'(way_hit) >> (WAY_W - l)) == k) begin
                        r_bits[index][(1 << l) - 1 + k] <= ~way_hit[WAY_W - 1 - l];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/cache_nway.sv
// N-way set-associative write-back / write-allocate cache with tree-PLRU
// replacement and saturating hit/miss/writeback counters.
module cache_nway
    import cache_types::*;
#(
    parameter int WAYS  = DEF_WAYS,
    parameter int SETS  = DEF_SETS,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [15:0]      mem_address,
    input  logic [15:0]      mem_wdata,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic [1:0]       mem_byte_enable,
    output logic [15:0]      mem_rdata,
    output logic             mem_resp,
    input  logic [127:0]     pmem_rdata,
    input  logic             pmem_resp,
    output logic [127:0]     pmem_wdata,
    output logic [15:0]      pmem_address,
    output logic             pmem_read,
    output logic             pmem_write,
    input  logic             perf_clear,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count,
    output logic [CNT_W-1:0] wb_count,
    output logic             hit_out,
    output logic             miss_out
);
    localparam int IDX_W = $clog2(SETS);
    localparam int WAY_W = $clog2(WAYS);
    localparam int TAG_W = 16 - 4 - IDX_W;

    cache_state_e      r_state, w_next_state;
    logic [WAYS-1:0]   r_valid [SETS];
    logic [WAYS-1:0]   r_dirty [SETS];
    logic [TAG_W-1:0]  r_tag   [SETS][WAYS];
    cache_line         r_data  [SETS][WAYS];
    logic [WAY_W-1:0]  r_victim;
    logic [TAG_W-1:0]  r_miss_tag;
    logic [IDX_W-1:0]  r_miss_idx;
    logic              r_after_fill;
    logic [CNT_W-1:0]  r_hit_cnt, r_miss_cnt, r_wb_cnt;

    logic [TAG_W-1:0]  w_tag;
    logic [IDX_W-1:0]  w_idx;
    logic [2:0]        w_word;
    logic              w_unused_addr0;
    logic              w_req, w_hit, w_any_inv, w_wr_hit, w_fill_done, w_wb_done, w_plru_upd;
    logic [WAY_W-1:0]  w_hit_way, w_inv_way, w_plru_victim, w_victim;
    cache_line         w_hit_line;
    logic [15:0]       w_hit_word;

    assign w_tag          = mem_address[15:4+IDX_W];
    assign w_idx          = mem_address[4+IDX_W-1:4];
    assign w_word         = mem_address[3:1];
    assign w_unused_addr0 = mem_address[0];
    assign w_req          = mem_read | mem_write;
    assign w_hit_line     = r_data[w_idx][w_hit_way];
    assign w_hit_word     = w_hit_line[{w_word, 4'h0} +: 16];
    assign mem_rdata      = w_hit ? w_hit_word : 16'h0000;
    assign pmem_wdata     = r_data[r_miss_idx][r_victim];
    assign hit_count      = r_hit_cnt;
    assign miss_count     = r_miss_cnt;
    assign wb_count       = r_wb_cnt;

    cache_plru #(.WAYS(WAYS), .SETS(SETS)) u_plru (
        .clk     (clk),
        .rst_n   (rst_n),
        .index   (w_idx),
        .update  (w_plru_upd),
        .way_hit (w_hit_way),
        .victim  (w_plru_victim)
    );

    // Tag match and lowest-numbered invalid way in the addressed set.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = '0;
        w_any_inv = 1'b0;
        w_inv_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag)) begin
                w_hit     = 1'b1;
                w_hit_way = WAY_W'(w);
            end else begin
                w_hit = w_hit;
            end
            if (!r_valid[w_idx][w]) begin
                w_any_inv = 1'b1;
                w_inv_way = WAY_W'(w);
            end else begin
                w_any_inv = w_any_inv;
            end
        end
        w_victim = w_any_inv ? w_inv_way : w_plru_victim;
    end

    // Next state and all request/response strobes.
    always_comb begin
        w_next_state = r_state;
        mem_resp     = 1'b0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = 16'h0000;
        hit_out      = 1'b0;
        miss_out     = 1'b0;
        w_wr_hit     = 1'b0;
        w_fill_done  = 1'b0;
        w_wb_done    = 1'b0;
        w_plru_upd   = 1'b0;
        case (r_state)
            ST_CHECK: begin
                if (w_req && w_hit) begin
                    mem_resp   = 1'b1;
                    w_plru_upd = 1'b1;
                    w_wr_hit   = mem_write;
                    hit_out    = ~r_after_fill;
                end else if (w_req) begin
                    miss_out     = 1'b1;
                    w_next_state = r_dirty[w_idx][w_victim] ? ST_WRITEBACK : ST_FILL;
                end else begin
                    w_next_state = ST_CHECK;
                end
            end
            ST_WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {r_tag[r_miss_idx][r_victim], r_miss_idx, 4'h0};
                if (pmem_resp) begin
                    w_wb_done    = 1'b1;
                    w_next_state = ST_FILL;
                end else begin
                    w_next_state = ST_WRITEBACK;
                end
            end
            ST_FILL: begin
                pmem_read    = 1'b1;
                pmem_address = {r_miss_tag, r_miss_idx, 4'h0};
                if (pmem_resp) begin
                    w_fill_done  = 1'b1;
                    w_next_state = ST_CHECK;
                end else begin
                    w_next_state = ST_FILL;
                end
            end
            default: w_next_state = ST_CHECK;
        endcase
    end

    // State register, miss context latch and the flag that hides the completing hit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_CHECK;
            r_victim     <= '0;
            r_miss_tag   <= '0;
            r_miss_idx   <= '0;
            r_after_fill <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_after_fill <= w_fill_done;
            if (miss_out) begin
                r_victim   <= w_victim;
                r_miss_tag <= w_tag;
                r_miss_idx <= w_idx;
            end
        end
    end

    // Valid and dirty bits: install on fill, mark dirty on write hit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                r_dirty[s] <= '0;
            end
        end else if (w_fill_done) begin
            r_valid[r_miss_idx][r_victim] <= 1'b1;
            r_dirty[r_miss_idx][r_victim] <= 1'b0;
        end else if (w_wr_hit) begin
            r_dirty[w_idx][w_hit_way] <= 1'b1;
        end
    end

    // Tag and data arrays: whole-line install on fill, byte-merged word on write hit.
    always_ff @(posedge clk) begin
        if (w_fill_done) begin
            r_tag[r_miss_idx][r_victim]  <= r_miss_tag;
            r_data[r_miss_idx][r_victim] <= pmem_rdata;
        end else if (w_wr_hit) begin
            r_data[w_idx][w_hit_way][{w_word, 4'h0} +: 16] <=
                merge_word(w_hit_word, mem_wdata, mem_byte_enable);
        end
    end

    // Saturating performance counters; clear wins over any increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
            r_wb_cnt   <= '0;
        end else if (perf_clear) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
            r_wb_cnt   <= '0;
        end else begin
            if (hit_out && (r_hit_cnt != {CNT_W{1'b1}}))
                r_hit_cnt <= r_hit_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            if (miss_out && (r_miss_cnt != {CNT_W{1'b1}}))
                r_miss_cnt <= r_miss_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            if (w_wb_done && (r_wb_cnt != {CNT_W{1'b1}}))
                r_wb_cnt <= r_wb_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_cache_nway.sv
// Self-checking bench for cache_nway: directed scenarios plus random traffic
// against a timestamp-based reference model of the cache and backing memory.
module tb_cache_nway;
    localparam int WAYS  = 4;
    localparam int SETS  = 16;
    localparam int CNT_W = 16;
    localparam int SATV  = 65535;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [15:0]      mem_address, mem_wdata, mem_rdata, pmem_address;
    logic             mem_read, mem_write, mem_resp, pmem_resp, pmem_read, pmem_write;
    logic [1:0]       mem_byte_enable;
    logic [127:0]     pmem_rdata, pmem_wdata;
    logic             perf_clear, hit_out, miss_out;
    logic [CNT_W-1:0] hit_count, miss_count, wb_count;

    always #5 clk = ~clk;

    cache_nway #(.WAYS(WAYS), .SETS(SETS), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_byte_enable(mem_byte_enable),
        .mem_rdata(mem_rdata), .mem_resp(mem_resp), .pmem_rdata(pmem_rdata),
        .pmem_resp(pmem_resp), .pmem_wdata(pmem_wdata), .pmem_address(pmem_address),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .perf_clear(perf_clear),
        .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count),
        .hit_out(hit_out), .miss_out(miss_out)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: per-way contents plus last-hit timestamps for PLRU.
    logic         m_valid [SETS][WAYS];
    logic         m_dirty [SETS][WAYS];
    logic [7:0]   m_tag   [SETS][WAYS];
    logic [127:0] m_data  [SETS][WAYS];
    longint       m_stamp [SETS][WAYS];
    longint       now = 0;
    logic [127:0] backing [logic [15:0]];
    int           exp_hit, exp_miss, exp_wb;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v > SATV) ? SATV : v;
    endfunction

    function automatic logic [127:0] init_line(input logic [15:0] la);
        logic [127:0] r;
        for (int i = 0; i < 8; i++) r[i*16 +: 16] = la ^ (16'h1357 * 16'(i + 1));
        return r;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) begin
                m_valid[s][w] = 1'b0; m_dirty[s][w] = 1'b0; m_stamp[s][w] = 0;
            end
        exp_hit = 0; exp_miss = 0; exp_wb = 0;
    endtask

    function automatic int find_hit(input int s, input logic [7:0] t);
        for (int w = 0; w < WAYS; w++) if (m_valid[s][w] && m_tag[s][w] == t) return w;
        return -1;
    endfunction

    // Tree-PLRU expressed as: at each split, descend into the half whose most
    // recent hit is older (never-hit halves tie and go left).
    function automatic int pick_victim(input int s);
        int lo, span, half;
        longint ml, mr;
        for (int w = 0; w < WAYS; w++) if (!m_valid[s][w]) return w;
        lo = 0; span = WAYS;
        while (span > 1) begin
            half = span / 2; ml = 0; mr = 0;
            for (int i = 0; i < half; i++) begin
                if (m_stamp[s][lo + i] > ml) ml = m_stamp[s][lo + i];
                if (m_stamp[s][lo + half + i] > mr) mr = m_stamp[s][lo + half + i];
            end
            if (mr < ml) lo = lo + half;
            span = half;
        end
        return lo;
    endfunction

    task automatic touch(input int s, input int w, input logic wr, input logic [15:0] wd,
                         input logic [1:0] be, input int wi);
        logic [15:0] old;
        now++;
        m_stamp[s][w] = now;
        if (wr) begin
            old = m_data[s][w][wi*16 +: 16];
            m_data[s][w][wi*16 +: 16] = {be[1] ? wd[15:8] : old[15:8], be[0] ? wd[7:0] : old[7:0]};
            m_dirty[s][w] = 1'b1;
        end
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_hits"}, hit_count, exp_hit);
        check({tag, "_misses"}, miss_count, exp_miss);
        check({tag, "_wbs"}, wb_count, exp_wb);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One CPU request from the negedge, acting as main memory on a miss.
    task automatic access(input logic [15:0] addr, input logic wr, input logic both,
                          input logic [15:0] wd, input logic [1:0] be, input logic drop);
        int s, wi, hw, v, lat;
        logic [7:0]   t;
        logic [15:0]  la;
        logic [127:0] line;
        s = int'(addr[7:4]); t = addr[15:8]; wi = int'(addr[3:1]);
        mem_address = addr; mem_wdata = wd; mem_byte_enable = be;
        mem_write = wr; mem_read = !wr || both;
        #1;
        hw = find_hit(s, t);
        if (hw >= 0) begin
            check("hit_resp", mem_resp, 1'b1);
            check("hit_pulse", hit_out, 1'b1);
            check("hit_no_miss", miss_out, 1'b0);
            if (!wr) check("hit_rdata", mem_rdata, m_data[s][hw][wi*16 +: 16]);
            touch(s, hw, wr, wd, be, wi);
            exp_hit = sat(exp_hit + 1);
            step();
        end else begin
            check("miss_pulse", miss_out, 1'b1);
            check("miss_no_resp", mem_resp, 1'b0);
            check("miss_no_hit", hit_out, 1'b0);
            exp_miss = sat(exp_miss + 1);
            v = pick_victim(s);
            step(); #1;
            if (m_valid[s][v] && m_dirty[s][v]) begin
                la = {m_tag[s][v], 4'(s), 4'h0};
                lat = $urandom_range(0, 2);
                for (int c = 0; c <= lat; c++) begin
                    check("wb_write", pmem_write, 1'b1);
                    check("wb_no_read", pmem_read, 1'b0);
                    check("wb_addr", pmem_address, la);
                    check("wb_data", pmem_wdata, m_data[s][v]);
                    if (c == lat) pmem_resp = 1'b1;
                    step(); pmem_resp = 1'b0; #1;
                end
                backing[la] = m_data[s][v];
                exp_wb = sat(exp_wb + 1);
            end
            la = addr & 16'hFFF0;
            line = backing.exists(la) ? backing[la] : init_line(la);
            if (drop) begin mem_read = 1'b0; mem_write = 1'b0; end
            lat = $urandom_range(0, 2);
            for (int c = 0; c <= lat; c++) begin
                check("fill_read", pmem_read, 1'b1);
                check("fill_no_write", pmem_write, 1'b0);
                check("fill_addr", pmem_address, la);
                check("fill_no_resp", mem_resp, 1'b0);
                if (c == lat) begin pmem_rdata = line; pmem_resp = 1'b1; end
                step();
                pmem_resp = 1'b0; pmem_rdata = {4{$urandom()}}; #1;
            end
            m_valid[s][v] = 1'b1; m_dirty[s][v] = 1'b0; m_tag[s][v] = t; m_data[s][v] = line;
            if (!drop) begin
                check("refill_resp", mem_resp, 1'b1);
                check("refill_no_hit_pulse", hit_out, 1'b0);
                check("refill_no_miss", miss_out, 1'b0);
                check("refill_no_pmem", pmem_read | pmem_write, 1'b0);
                if (!wr) check("refill_rdata", mem_rdata, line[wi*16 +: 16]);
                touch(s, v, wr, wd, be, wi);
            end else begin
                check("drop_no_resp", mem_resp, 1'b0);
            end
            step();
        end
        mem_read = 1'b0; mem_write = 1'b0;
    endtask

    initial begin
        logic [127:0] tmp;
        rst_n = 1'b0; mem_address = 16'h0; mem_wdata = 16'h0; mem_read = 1'b0; mem_write = 1'b0;
        mem_byte_enable = 2'b11; pmem_rdata = '0; pmem_resp = 1'b0; perf_clear = 1'b0;
        model_reset();
        repeat (2) step();
        #1;
        check("rst_mem_resp", mem_resp, 1'b0);
        check("rst_pmem_read", pmem_read, 1'b0);
        check("rst_pmem_write", pmem_write, 1'b0);
        check("rst_hit_out", hit_out, 1'b0);
        check("rst_miss_out", miss_out, 1'b0);
        check_counters("rst");
        @(negedge clk); rst_n = 1'b1;
        step();

        // Cold read then repeat read.
        access(16'h1234, 1'b0, 1'b0, 16'h0, 2'b11, 1'b0);
        check("cold_miss_count", miss_count, 16'd1);
        check("cold_hit_count", hit_count, 16'd0);
        access(16'h1234, 1'b0, 1'b0, 16'h0, 2'b11, 1'b0);
        check("repeat_hit_count", hit_count, 16'd1);

        // Reset in the middle of a fill.
        mem_address = 16'h5670; mem_read = 1'b1; #1;
        check("rstfill_miss", miss_out, 1'b1);
        step(); #1;
        check("rstfill_pmem_read", pmem_read, 1'b1);
        rst_n = 1'b0; mem_read = 1'b0; #1;
        check("rstfill_read_drop", pmem_read, 1'b0);
        check("rstfill_no_write", pmem_write, 1'b0);
        check("rstfill_no_resp", mem_resp, 1'b0);
        check("rstfill_no_pulses", hit_out | miss_out, 1'b0);
        model_reset();
        check_counters("rstfill");
        step(); rst_n = 1'b1; step();
        access(16'h5670, 1'b0, 1'b0, 16'h0, 2'b11, 1'b0);
        check_counters("after_rst");

        // Byte-enable write then read back.
        access(16'h0042, 1'b1, 1'b0, 16'hBEEF, 2'b01, 1'b0);
        mem_address = 16'h0042; mem_read = 1'b1; #1;
        tmp = init_line(16'h0040);
        check("be_merge_rdata", mem_rdata, {tmp[31:24], 8'hEF});
        check("be_merge_resp", mem_resp, 1'b1);
        touch(4, find_hit(4, 8'h00), 1'b0, 16'h0, 2'b00, 1);
        exp_hit = sat(exp_hit + 1);
        step(); mem_read = 1'b0;

        // Four dirty lines in set 0, then a fifth tag forces a PLRU writeback.
        for (int i = 0; i < 4; i++) access(16'(i * 256), 1'b1, 1'b0, 16'(16'hA000 + i), 2'b11, 1'b0);
        access(16'h0400, 1'b0, 1'b0, 16'h0, 2'b11, 1'b0);
        check("fifth_tag_wb_count", wb_count, 16'd1);
        // Evicting set 4 must write back the byte-merged line (proves it stayed dirty).
        for (int i = 1; i < 5; i++) access(16'(i * 256 + 16'h0042), 1'b0, 1'b0, 16'h0, 2'b11, 1'b0);
        check("dirty_evict_wb_count", wb_count, 16'd2);
        check_counters("directed");

        // Request dropped during fill: line still installed, later read hits.
        access(16'h3A5E, 1'b0, 1'b0, 16'h0, 2'b11, 1'b1);
        access(16'h3A5E, 1'b0, 1'b0, 16'h0, 2'b11, 1'b0);
        check_counters("drop");

        // Random traffic over a few crowded sets.
        for (int n = 0; n < 300; n++) begin
            logic [15:0] a;
            logic wr, both, drop;
            a = {8'($urandom_range(0, 5)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 15))};
            wr = 1'($urandom_range(0, 1));
            both = wr && ($urandom_range(0, 3) == 0);
            drop = ($urandom_range(0, 15) == 0);
            access(a, wr, both, 16'($urandom()), 2'($urandom_range(0, 3)), drop);
            check_counters("random");
        end

        // Saturation of hit_count, then clear racing a hit.
        access(16'h1234, 1'b0, 1'b0, 16'h0, 2'b11, 1'b0);
        perf_clear = 1'b1; step(); perf_clear = 1'b0;
        exp_hit = 0; exp_miss = 0; exp_wb = 0;
        check_counters("cleared");
        mem_address = 16'h1234; mem_read = 1'b1;
        repeat (65536) @(posedge clk);
        @(negedge clk); mem_read = 1'b0;
        touch(3, find_hit(3, 8'h12), 1'b0, 16'h0, 2'b00, 2);
        exp_hit = sat(exp_hit + 65536);
        check("hit_saturated", hit_count, 16'hFFFF);
        check_counters("saturated");
        mem_read = 1'b1; perf_clear = 1'b1; #1;
        check("clear_hit_resp", mem_resp, 1'b1);
        step(); mem_read = 1'b0; perf_clear = 1'b0;
        exp_hit = 0; exp_miss = 0; exp_wb = 0;
        check_counters("clear_with_hit");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
